timer_compare_unit: RTL and testbench
=====================================

Name: timer_compare_unit

Overview:
- Downstream stage of the 8-bit timer Counter. Consumes its TCNT and Overflow outputs.
- Generates sticky compare-match and overflow flags, a masked interrupt, and a waveform output pin (OC).
- Runs on the system clock. Counter outputs come from the slower CounterClock domain and are resynchronised here.

Parameters:
- BIT_WIDTH, 8, width of TCNT and of the compare register. Must equal the Counter's BIT_WIDTH.

Ports:
- SystemClock  input  1  block clock. All logic updates on its rising edge.
- SystemReset  input  1  synchronous, active-high reset.
- TCNT  input  BIT_WIDTH  count value from Counter. Changes at most once per 4 SystemClock cycles.
- Overflow  input  1  overflow indication from Counter. Level held at least 2 SystemClock cycles.
- OcrWrite  input  1  write strobe for the compare register.
- OcrData  input  BIT_WIDTH  compare value to write.
- IntEnable  input  2  bit0 enables the compare interrupt; bit1 enables the overflow interrupt.
- FlagClear  input  2  write-one-to-clear. bit0 clears CmpFlag; bit1 clears OvfFlag. One-cycle pulse.
- WaveMode  input  2  OC mode: 00 off, 01 toggle, 10 PWM non-inverted, 11 PWM inverted.
- OcrActive  output  BIT_WIDTH  compare value currently in use.
- CmpFlag  output  1  sticky compare-match flag.
- OvfFlag  output  1  sticky overflow flag.
- Interrupt  output  1  (CmpFlag & IntEnable[0]) | (OvfFlag & IntEnable[1]). Combinational from registers.
- OC  output  1  waveform output. Registered.

Behaviour:
- Reset values: OcrActive=0, OCR shadow=0, CmpFlag=0, OvfFlag=0, OC=0. All sync flops and the accepted-count register are 0.
- Reset applied mid-operation wins over every other event in that cycle.
- Overflow path:
  - 2-flop synchroniser, then a third flop for rising-edge detection.
  - OvfEvent = sync2 & ~sync3.
  - If Overflow rises before edge k, OvfFlag is 1 after edge k+2.
  - One event per Overflow rising edge, regardless of how long Overflow stays high.
- TCNT path:
  - Two sample registers s1 and s2, plus the accepted-count register TcntQ.
  - NewCount = (s1==s2) & (s2!=TcntQ). On NewCount, TcntQ<=s2.
  - MatchEvent = NewCount & (s2==OcrActive).
  - If TCNT changes before edge k, CmpFlag is 1 after edge k+2.
  - A value that stays static never re-matches. A match requires a change of count.
  - With OcrActive=0, a match fires on the wrap from max to 0.
- Flags:
  - Set by their event; cleared by the corresponding FlagClear bit.
  - A set and a clear in the same cycle: set wins, flag stays 1.
- Waveform, evaluated on each event:
  - 00: OC held 0.
  - 01: OC toggles on MatchEvent.
  - 10: OC<=1 on OvfEvent, OC<=0 on MatchEvent.
  - 11: OC<=0 on OvfEvent, OC<=1 on MatchEvent.
  - MatchEvent and OvfEvent in the same cycle: the match action wins. Result is 0% duty at OCR=0 in mode 10.
  - A WaveMode change takes effect at the next event. Mode 00 forces OC=0 on the next edge.
- OCR load: see Optional Feature. OcrWrite without the feature: OcrActive<=OcrData on the next edge.
- Width rules: all comparisons are unsigned and exactly BIT_WIDTH wide. There is no arithmetic on TCNT.

Optional Feature:
- Macro: OCR_DOUBLE_BUFFER_EN.
- Defined:
  - OcrWrite loads the shadow register only.
  - OcrActive<=shadow on OvfEvent.
  - If OcrWrite coincides with OvfEvent, OcrData is forwarded directly into OcrActive and also into the shadow.
  - Glitch-free PWM updates.
- Undefined:
  - No shadow register.
  - OcrWrite updates OcrActive immediately, on the next edge.

Test Plan:
- Reset: hold SystemReset 2 cycles while TCNT=8'h55 and Overflow=1 → OcrActive=0, CmpFlag=0, OvfFlag=0, OC=0, Interrupt=0. After release, no OvfEvent until Overflow falls and rises again.
- Compare and toggle: OCR=8'h40, IntEnable=01, WaveMode=01. Step TCNT 3F→40 → CmpFlag=1 and OC 0→1 after the 3rd edge, Interrupt=1. Hold 40 for 20 cycles → no further toggle. FlagClear=01 → CmpFlag=0, Interrupt=0.
- Overflow set/clear race: Overflow rises → OvfFlag=1 after 3 edges. Pulse FlagClear=10 in the same cycle as a second OvfEvent → OvfFlag stays 1. Pulse it alone → OvfFlag=0.
- PWM mode 10, OCR=8'h80, TCNT cycling 00..FF with Overflow at wrap → OC=1 after each overflow, 0 after TCNT reaches 80. With OCR=0 → OC stays 0.
- Double buffer with OCR_DOUBLE_BUFFER_EN, active=8'h40: write 8'h80 → OcrActive stays 40, match still at 40. After the next OvfEvent → OcrActive=80. Without the macro → OcrActive=80 one edge after the write.
- Reset mid-run: assert SystemReset in the same cycle as a pending MatchEvent → no flag set, OC=0, all registers at reset values.

Source files
------------

// File: rtl/timer_compare_unit_if.sv
// Signal bundle between the timer Counter/CPU side and timer_compare_unit.
// The master drives the count, overflow and register-write inputs; the slave returns status and OC.
interface timer_compare_unit_if #(
    parameter int unsigned BIT_WIDTH = 8
);
    logic [BIT_WIDTH-1:0] TCNT;
    logic                 Overflow;
    logic                 OcrWrite;
    logic [BIT_WIDTH-1:0] OcrData;
    logic [1:0]           IntEnable;
    logic [1:0]           FlagClear;
    logic [1:0]           WaveMode;
    logic [BIT_WIDTH-1:0] OcrActive;
    logic                 CmpFlag;
    logic                 OvfFlag;
    logic                 Interrupt;
    logic                 OC;

    modport master (
        output TCNT, Overflow, OcrWrite, OcrData, IntEnable, FlagClear, WaveMode,
        input  OcrActive, CmpFlag, OvfFlag, Interrupt, OC
    );

    modport slave (
        input  TCNT, Overflow, OcrWrite, OcrData, IntEnable, FlagClear, WaveMode,
        output OcrActive, CmpFlag, OvfFlag, Interrupt, OC
    );
endinterface

// File: rtl/timer_compare_unit.sv
// Compare/overflow flags, masked interrupt and OC waveform stage behind the timer Counter.
// Optional macro OCR_DOUBLE_BUFFER_EN: compare writes go to a shadow register loaded on overflow.
module timer_compare_unit #(
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic                SystemClock,
    input  logic                SystemReset,
    timer_compare_unit_if.slave bus
);
    localparam int unsigned SYNC_DEPTH = 3;
    localparam int unsigned FILL_DEPTH = 2;

    typedef logic [BIT_WIDTH-1:0] count_t;

    logic [SYNC_DEPTH-1:0] ovf_sync_q, ovf_sync_d;
    logic [FILL_DEPTH-1:0] ovf_fill_q, ovf_fill_d;
    logic                  ovf_armed_q, ovf_armed_d;
    count_t                s1_q, s1_d;
    count_t                s2_q, s2_d;
    count_t                tcnt_q, tcnt_d;
    count_t                ocr_active_q, ocr_active_d;
`ifdef OCR_DOUBLE_BUFFER_EN
    count_t                ocr_shadow_q, ocr_shadow_d;
`endif
    logic                  cmp_flag_q, cmp_flag_d;
    logic                  ovf_flag_q, ovf_flag_d;
    logic                  oc_q, oc_d;
    logic                  ovf_event;
    logic                  new_count;
    logic                  match_event;

    // Edge detect is armed only once the synchroniser has seen Overflow low after reset,
    // so a level already high across reset does not count as a rising edge.
    always_comb begin
        ovf_event   = ovf_sync_q[1] & ~ovf_sync_q[2] & ovf_armed_q;
        new_count   = (s1_q == s2_q) && (s2_q != tcnt_q);
        match_event = new_count && (s2_q == ocr_active_q);
    end

    always_comb begin
        ovf_sync_d   = {ovf_sync_q[SYNC_DEPTH-2:0], bus.Overflow};
        ovf_fill_d   = {ovf_fill_q[FILL_DEPTH-2:0], 1'b1};
        ovf_armed_d  = ovf_armed_q | (ovf_fill_q[FILL_DEPTH-1] & ~ovf_sync_q[1]);
        s1_d         = bus.TCNT;
        s2_d         = s1_q;
        tcnt_d       = new_count ? s2_q : tcnt_q;
        cmp_flag_d   = match_event | (cmp_flag_q & ~bus.FlagClear[0]);
        ovf_flag_d   = ovf_event   | (ovf_flag_q & ~bus.FlagClear[1]);
        oc_d         = oc_q;
        ocr_active_d = ocr_active_q;
`ifdef OCR_DOUBLE_BUFFER_EN
        ocr_shadow_d = ocr_shadow_q;
        if (bus.OcrWrite) begin
            ocr_shadow_d = bus.OcrData;
        end
        if (ovf_event) begin
            ocr_active_d = bus.OcrWrite ? bus.OcrData : ocr_shadow_q;
        end
`else
        if (bus.OcrWrite) begin
            ocr_active_d = bus.OcrData;
        end
`endif
        // Match action has priority over overflow action in the PWM modes.
        case (bus.WaveMode)
            2'b00: oc_d = 1'b0;
            2'b01: begin
                if (match_event) oc_d = ~oc_q;
            end
            2'b10: begin
                if (match_event)    oc_d = 1'b0;
                else if (ovf_event) oc_d = 1'b1;
            end
            default: begin
                if (match_event)    oc_d = 1'b1;
                else if (ovf_event) oc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SystemClock) begin
        if (SystemReset) begin
            ovf_sync_q   <= '0;
            ovf_fill_q   <= '0;
            ovf_armed_q  <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            tcnt_q       <= '0;
            ocr_active_q <= '0;
`ifdef OCR_DOUBLE_BUFFER_EN
            ocr_shadow_q <= '0;
`endif
            cmp_flag_q   <= 1'b0;
            ovf_flag_q   <= 1'b0;
            oc_q         <= 1'b0;
        end else begin
            ovf_sync_q   <= ovf_sync_d;
            ovf_fill_q   <= ovf_fill_d;
            ovf_armed_q  <= ovf_armed_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            tcnt_q       <= tcnt_d;
            ocr_active_q <= ocr_active_d;
`ifdef OCR_DOUBLE_BUFFER_EN
            ocr_shadow_q <= ocr_shadow_d;
`endif
            cmp_flag_q   <= cmp_flag_d;
            ovf_flag_q   <= ovf_flag_d;
            oc_q         <= oc_d;
        end
    end

    assign bus.OcrActive = ocr_active_q;
    assign bus.CmpFlag   = cmp_flag_q;
    assign bus.OvfFlag   = ovf_flag_q;
    assign bus.OC        = oc_q;
    assign bus.Interrupt = (cmp_flag_q & bus.IntEnable[0]) | (ovf_flag_q & bus.IntEnable[1]);
endmodule

// File: tb/tb_timer_compare_unit.sv
// Bench for timer_compare_unit: directed scenarios plus a randomized run against a
// transaction-level model. Honors OCR_DOUBLE_BUFFER_EN when defined for the build.
module tb_timer_compare_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    timer_compare_unit_if #(.BIT_WIDTH(8)) tb_if ();

    timer_compare_unit #(.BIT_WIDTH(8)) dut (
        .SystemClock (clk),
        .SystemReset (rst),
        .bus         (tb_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ovf_pulse();
        tb_if.Overflow = 1'b1;
        tick(3);
        tb_if.Overflow = 1'b0;
        tick(3);
    endtask

    // Leaves OcrActive == v in either build; the buffered build needs an overflow to load it.
    task automatic load_ocr(input logic [7:0] v);
        tb_if.OcrWrite = 1'b1;
        tb_if.OcrData  = v;
        tick(1);
        tb_if.OcrWrite = 1'b0;
`ifdef OCR_DOUBLE_BUFFER_EN
        ovf_pulse();
        tb_if.FlagClear = 2'b10;
        tick(1);
        tb_if.FlagClear = 2'b00;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tb_if.TCNT = 8'h55;
        tb_if.Overflow = 1'b1;
        tb_if.OcrWrite = 1'b0;
        tb_if.OcrData = 8'h00;
        tb_if.IntEnable = 2'b11;
        tb_if.FlagClear = 2'b00;
        tb_if.WaveMode = 2'b01;
        tick(2);
        checks++; if (tb_if.OcrActive !== 8'h00) begin failures++; $display("FAIL reset_ocr: got %h expected 00", tb_if.OcrActive); end
        checks++; if (tb_if.CmpFlag !== 1'b0) begin failures++; $display("FAIL reset_cmp: got %b expected 0", tb_if.CmpFlag); end
        checks++; if (tb_if.OvfFlag !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", tb_if.OvfFlag); end
        checks++; if (tb_if.OC !== 1'b0) begin failures++; $display("FAIL reset_oc: got %b expected 0", tb_if.OC); end
        checks++; if (tb_if.Interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", tb_if.Interrupt); end
        rst = 1'b0;
        tick(6);
        checks++; if (tb_if.OvfFlag !== 1'b0) begin failures++; $display("FAIL reset_held_ovf: got %b expected 0", tb_if.OvfFlag); end
        checks++; if (tb_if.CmpFlag !== 1'b0) begin failures++; $display("FAIL reset_held_cmp: got %b expected 0", tb_if.CmpFlag); end
        tb_if.Overflow = 1'b0;
        tick(4);
        tb_if.Overflow = 1'b1;
        tick(3);
        checks++; if (tb_if.OvfFlag !== 1'b1) begin failures++; $display("FAIL reset_rearm_ovf: got %b expected 1", tb_if.OvfFlag); end
        tb_if.Overflow = 1'b0;
        tb_if.FlagClear = 2'b10;
        tick(1);
        tb_if.FlagClear = 2'b00;
        tick(3);
        checks++; if (tb_if.OvfFlag !== 1'b0) begin failures++; $display("FAIL reset_clear_ovf: got %b expected 0", tb_if.OvfFlag); end
    endtask

    task automatic test_compare_toggle();
        tb_if.IntEnable = 2'b01;
        tb_if.WaveMode = 2'b01;
        load_ocr(8'h40);
        tb_if.TCNT = 8'h3F;
        tick(4);
        tb_if.TCNT = 8'h40;
        tick(2);
        checks++; if (tb_if.CmpFlag !== 1'b0) begin failures++; $display("FAIL cmp_early: got %b expected 0", tb_if.CmpFlag); end
        tick(1);
        checks++; if (tb_if.CmpFlag !== 1'b1) begin failures++; $display("FAIL cmp_set: got %b expected 1", tb_if.CmpFlag); end
        checks++; if (tb_if.OC !== 1'b1) begin failures++; $display("FAIL cmp_toggle: got %b expected 1", tb_if.OC); end
        checks++; if (tb_if.Interrupt !== 1'b1) begin failures++; $display("FAIL cmp_irq: got %b expected 1", tb_if.Interrupt); end
        tick(20);
        checks++; if (tb_if.OC !== 1'b1) begin failures++; $display("FAIL cmp_static_hold: got %b expected 1", tb_if.OC); end
        tb_if.FlagClear = 2'b01;
        tick(1);
        tb_if.FlagClear = 2'b00;
        checks++; if (tb_if.CmpFlag !== 1'b0) begin failures++; $display("FAIL cmp_clear: got %b expected 0", tb_if.CmpFlag); end
        checks++; if (tb_if.Interrupt !== 1'b0) begin failures++; $display("FAIL cmp_clear_irq: got %b expected 0", tb_if.Interrupt); end
    endtask

    task automatic test_overflow_race();
        tb_if.IntEnable = 2'b10;
        tb_if.Overflow = 1'b1;
        tick(2);
        checks++; if (tb_if.OvfFlag !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", tb_if.OvfFlag); end
        tick(1);
        checks++; if (tb_if.OvfFlag !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", tb_if.OvfFlag); end
        checks++; if (tb_if.Interrupt !== 1'b1) begin failures++; $display("FAIL ovf_irq: got %b expected 1", tb_if.Interrupt); end
        tb_if.Overflow = 1'b0;
        tick(3);
        tb_if.Overflow = 1'b1;
        tick(2);
        tb_if.FlagClear = 2'b10;
        tick(1);
        tb_if.FlagClear = 2'b00;
        checks++; if (tb_if.OvfFlag !== 1'b1) begin failures++; $display("FAIL ovf_set_wins: got %b expected 1", tb_if.OvfFlag); end
        tb_if.FlagClear = 2'b10;
        tick(1);
        tb_if.FlagClear = 2'b00;
        checks++; if (tb_if.OvfFlag !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", tb_if.OvfFlag); end
        tb_if.Overflow = 1'b0;
        tick(3);
    endtask

    task automatic test_pwm();
        logic [7:0] ocr_vals [2];
        logic       exp_oc;
        ocr_vals[0] = 8'h80;
        ocr_vals[1] = 8'h00;
        tb_if.WaveMode = 2'b10;
        tb_if.IntEnable = 2'b00;
        for (int c = 0; c < 2; c++) begin
            load_ocr(ocr_vals[c]);
            for (int pass = 0; pass < 2; pass++) begin
                for (int v = 0; v < 256; v++) begin
                    tb_if.TCNT = 8'(v);
                    if (v == 0) tb_if.Overflow = 1'b1;
                    if (v == 2) tb_if.Overflow = 1'b0;
                    tick(4);
                    if (v == 0 || v == 8'h7F || v == 8'h80 || v == 8'hFF) begin
                        exp_oc = (ocr_vals[c] != 8'h00) && (v < int'(ocr_vals[c]));
                        checks++;
                        if (tb_if.OC !== exp_oc) begin
                            failures++;
                            $display("FAIL pwm_oc ocr=%h tcnt=%h: got %b expected %b", ocr_vals[c], v, tb_if.OC, exp_oc);
                        end
                    end
                end
            end
        end
        tb_if.FlagClear = 2'b11;
        tick(1);
        tb_if.FlagClear = 2'b00;
    endtask

    task automatic test_double_buffer();
        tb_if.WaveMode = 2'b01;
        tb_if.IntEnable = 2'b01;
        load_ocr(8'h40);
        tb_if.TCNT = 8'h3F;
        tick(4);
        tb_if.FlagClear = 2'b01;
        tick(1);
        tb_if.FlagClear = 2'b00;
        tb_if.OcrWrite = 1'b1;
        tb_if.OcrData = 8'h80;
        tick(1);
        tb_if.OcrWrite = 1'b0;
`ifdef OCR_DOUBLE_BUFFER_EN
        checks++; if (tb_if.OcrActive !== 8'h40) begin failures++; $display("FAIL db_hold: got %h expected 40", tb_if.OcrActive); end
        tb_if.TCNT = 8'h40;
        tick(4);
        checks++; if (tb_if.CmpFlag !== 1'b1) begin failures++; $display("FAIL db_old_match: got %b expected 1", tb_if.CmpFlag); end
        ovf_pulse();
        checks++; if (tb_if.OcrActive !== 8'h80) begin failures++; $display("FAIL db_load: got %h expected 80", tb_if.OcrActive); end
`else
        checks++; if (tb_if.OcrActive !== 8'h80) begin failures++; $display("FAIL direct_load: got %h expected 80", tb_if.OcrActive); end
        tb_if.TCNT = 8'h40;
        tick(4);
        checks++; if (tb_if.CmpFlag !== 1'b0) begin failures++; $display("FAIL direct_no_match: got %b expected 0", tb_if.CmpFlag); end
`endif
        tb_if.Overflow = 1'b1;
        tick(2);
        tb_if.OcrWrite = 1'b1;
        tb_if.OcrData = 8'hC3;
        tick(1);
        tb_if.OcrWrite = 1'b0;
        checks++; if (tb_if.OcrActive !== 8'hC3) begin failures++; $display("FAIL write_on_ovf: got %h expected c3", tb_if.OcrActive); end
        tb_if.Overflow = 1'b0;
        tick(3);
        ovf_pulse();
        checks++; if (tb_if.OcrActive !== 8'hC3) begin failures++; $display("FAIL write_on_ovf_shadow: got %h expected c3", tb_if.OcrActive); end
        tb_if.FlagClear = 2'b11;
        tick(1);
        tb_if.FlagClear = 2'b00;
    endtask

    task automatic test_reset_mid();
        tb_if.WaveMode = 2'b11;
        tb_if.IntEnable = 2'b11;
        ovf_pulse();
        tb_if.TCNT = 8'hC3;
        tick(2);
        rst = 1'b1;
        tick(1);
        checks++; if (tb_if.CmpFlag !== 1'b0) begin failures++; $display("FAIL mid_reset_cmp: got %b expected 0", tb_if.CmpFlag); end
        checks++; if (tb_if.OvfFlag !== 1'b0) begin failures++; $display("FAIL mid_reset_ovf: got %b expected 0", tb_if.OvfFlag); end
        checks++; if (tb_if.OC !== 1'b0) begin failures++; $display("FAIL mid_reset_oc: got %b expected 0", tb_if.OC); end
        checks++; if (tb_if.OcrActive !== 8'h00) begin failures++; $display("FAIL mid_reset_ocr: got %h expected 00", tb_if.OcrActive); end
        checks++; if (tb_if.Interrupt !== 1'b0) begin failures++; $display("FAIL mid_reset_irq: got %b expected 0", tb_if.Interrupt); end
        tick(1);
        rst = 1'b0;
        tick(4);
    endtask

    // Transaction-level model: each action completes before the next, events are applied
    // once per accepted count change / overflow rise, match outranks overflow for OC.
    task automatic test_random();
        logic [7:0] m_ocr, m_shadow, m_acc, nv, d;
        logic       m_cmp, m_ovf, m_oc, mt, ov, exp_irq;
        logic [1:0] fc;
        int         act;
        rst = 1'b1;
        tb_if.Overflow = 1'b0;
        tb_if.OcrWrite = 1'b0;
        tb_if.FlagClear = 2'b00;
        tick(2);
        rst = 1'b0;
        tick(4);
        m_ocr = 8'h00; m_shadow = 8'h00; m_acc = tb_if.TCNT;
        m_cmp = 1'b0; m_ovf = 1'b0; m_oc = 1'b0;
        for (int it = 0; it < 300; it++) begin
            act = int'($urandom_range(0, 5));
            mt = 1'b0;
            ov = 1'b0;
            case (act)
                0, 5: begin
                    if ($urandom_range(0, 2) == 0) nv = m_ocr;
                    else if ($urandom_range(0, 4) == 0) nv = m_acc;
                    else nv = 8'($urandom);
                    tb_if.TCNT = nv;
                    if (act == 5) tb_if.Overflow = 1'b1;
                    tick(4);
                    if (act == 5) begin
                        tb_if.Overflow = 1'b0;
                        tick(3);
                        ov = 1'b1;
                    end
                    if (nv != m_acc) begin
                        m_acc = nv;
                        mt = (nv == m_ocr);
                    end
                end
                1: begin
                    ovf_pulse();
                    ov = 1'b1;
                end
                2: begin
                    d = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) d = m_acc;
                    tb_if.OcrWrite = 1'b1;
                    tb_if.OcrData = d;
                    tick(1);
                    tb_if.OcrWrite = 1'b0;
`ifdef OCR_DOUBLE_BUFFER_EN
                    m_shadow = d;
`else
                    m_ocr = d;
`endif
                end
                3: begin
                    fc = 2'($urandom);
                    tb_if.FlagClear = fc;
                    tick(1);
                    tb_if.FlagClear = 2'b00;
                    if (fc[0]) m_cmp = 1'b0;
                    if (fc[1]) m_ovf = 1'b0;
                end
                default: begin
                    tb_if.WaveMode = 2'($urandom);
                    tb_if.IntEnable = 2'($urandom);
                    tick(1);
                end
            endcase
            if (mt) m_cmp = 1'b1;
            if (ov) m_ovf = 1'b1;
            case (tb_if.WaveMode)
                2'b01: if (mt) m_oc = ~m_oc;
                2'b10: if (mt) m_oc = 1'b0; else if (ov) m_oc = 1'b1;
                2'b11: if (mt) m_oc = 1'b1; else if (ov) m_oc = 1'b0;
                default: m_oc = 1'b0;
            endcase
`ifdef OCR_DOUBLE_BUFFER_EN
            if (ov) m_ocr = m_shadow;
`endif
            exp_irq = (m_cmp & tb_if.IntEnable[0]) | (m_ovf & tb_if.IntEnable[1]);
            checks++; if (tb_if.OcrActive !== m_ocr) begin failures++; $display("FAIL rand_ocr it=%0d: got %h expected %h", it, tb_if.OcrActive, m_ocr); end
            checks++; if (tb_if.CmpFlag !== m_cmp) begin failures++; $display("FAIL rand_cmp it=%0d: got %b expected %b", it, tb_if.CmpFlag, m_cmp); end
            checks++; if (tb_if.OvfFlag !== m_ovf) begin failures++; $display("FAIL rand_ovf it=%0d: got %b expected %b", it, tb_if.OvfFlag, m_ovf); end
            checks++; if (tb_if.OC !== m_oc) begin failures++; $display("FAIL rand_oc it=%0d: got %b expected %b", it, tb_if.OC, m_oc); end
            checks++; if (tb_if.Interrupt !== exp_irq) begin failures++; $display("FAIL rand_irq it=%0d: got %b expected %b", it, tb_if.Interrupt, exp_irq); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_compare_toggle();
        test_overflow_race();
        test_pwm();
        test_double_buffer();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
